reorder_buffer: RTL and testbench

Circular reorder buffer downstream of the functional-unit output buffers. It allocates one tag per issued instruction, captures results broadcast on the CDB, and retires results in program order to the register file. The allocated tag is the reorder_buffer_tag handed to reservation stations. Operand lookup ports let issue logic fetch completed-but-uncommitted values.

---
 rtl/rob_pkg.sv | 19 +
 rtl/reorder_buffer_wrap_pointer.sv | 31 +++
 rtl/reorder_buffer.sv | 160 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Reorder buffer shared types and constants.
// The entry record below is sized by the package constants; reorder_buffer
// checks at elaboration time that its parameters agree with them.
package rob_pkg;

  localparam int unsigned ROB_XLEN      = 32;
  localparam int unsigned ROB_DEPTH     = 8;
  localparam int unsigned ROB_RD_WIDTH  = 5;
  // Tag width is derived from the depth; the top checks TAG_WIDTH against it.
  localparam int unsigned ROB_TAG_WIDTH = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic                    valid;
    logic                    ready;
    logic [ROB_RD_WIDTH-1:0] rd;
    logic [ROB_XLEN-1:0]     value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_wrap_pointer.sv
// wrap_pointer: modulo-DEPTH counter with increment enable.
// Ports:
//   i_clk   - clock
//   i_reset - synchronous active-high reset (pointer -> 0)
//   i_clear - synchronous clear (pointer -> 0), same effect as reset
//   i_inc   - advance pointer by one, wrapping DEPTH-1 -> 0
//   o_ptr   - current pointer value
module wrap_pointer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == WIDTH'(DEPTH - 1)) ? '0 : r_ptr + WIDTH'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB. Allocates a tag per issued instruction,
// captures CDB results, and retires them in program order.
// Ports:
//   clk, reset (sync, active-high), flush (discard all entries)
//   alloc_valid/alloc_rd in, alloc_ready/alloc_tag out   - issue allocation
//   cdb_active/cdb_tag/cdb_data in                        - result writeback
//   commit_valid/commit_rd/commit_value/commit_tag out,
//   commit_ready in                                       - in-order retire
//   lookup_tag1/2 in, lookup_ready1/2, lookup_value1/2 out - operand lookup
//   count out                                             - occupied entries
// Configuration macro: ROB_CDB_BYPASS_EN - when defined, lookups also see
// the result currently on the CDB for a valid entry in the same cycle.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int unsigned XLEN          = ROB_XLEN,
  parameter int unsigned ROB_SIZE      = ROB_DEPTH,
  parameter int unsigned TAG_WIDTH     = ROB_TAG_WIDTH,
  parameter int unsigned REG_IDX_WIDTH = ROB_RD_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic [REG_IDX_WIDTH-1:0] alloc_rd,
  output logic                     alloc_ready,
  output logic [TAG_WIDTH-1:0]     alloc_tag,
  input  logic                     cdb_active,
  input  logic [TAG_WIDTH-1:0]     cdb_tag,
  input  logic [XLEN-1:0]          cdb_data,
  output logic                     commit_valid,
  input  logic                     commit_ready,
  output logic [REG_IDX_WIDTH-1:0] commit_rd,
  output logic [XLEN-1:0]          commit_value,
  output logic [TAG_WIDTH-1:0]     commit_tag,
  input  logic [TAG_WIDTH-1:0]     lookup_tag1,
  input  logic [TAG_WIDTH-1:0]     lookup_tag2,
  output logic                     lookup_ready1,
  output logic                     lookup_ready2,
  output logic [XLEN-1:0]          lookup_value1,
  output logic [XLEN-1:0]          lookup_value2,
  output logic [TAG_WIDTH:0]       count
);

  // The entry struct is sized by the package, so the parameters must match it.
  if ((TAG_WIDTH != $clog2(ROB_SIZE)) || (ROB_SIZE != ROB_DEPTH) ||
      (XLEN != ROB_XLEN) || (REG_IDX_WIDTH != ROB_RD_WIDTH)) begin : g_cfg_err
    $error("reorder_buffer: parameters inconsistent with rob_pkg");
  end

  rob_entry_t               r_entries [ROB_SIZE];
  logic [TAG_WIDTH:0]       r_count;
  logic [TAG_WIDTH-1:0]     w_head;
  logic [TAG_WIDTH-1:0]     w_tail;
  logic                     w_alloc_fire;
  logic                     w_commit_fire;
  logic                     w_cdb_write;
  rob_entry_t               w_head_entry;
  rob_entry_t               w_cdb_entry;
  rob_entry_t               w_lk1_entry;
  rob_entry_t               w_lk2_entry;

  assign w_head_entry = r_entries[w_head];
  assign w_cdb_entry  = r_entries[cdb_tag];

  // Uses the registered count only: a full ROB rejects allocation even when
  // the head retires in the same cycle.
  assign alloc_ready   = (r_count < (TAG_WIDTH + 1)'(ROB_SIZE));
  assign alloc_tag     = w_tail;
  assign w_alloc_fire  = alloc_valid && alloc_ready && !flush;

  assign commit_valid  = w_head_entry.valid && w_head_entry.ready && !flush;
  assign commit_rd     = w_head_entry.rd;
  assign commit_value  = w_head_entry.value;
  assign commit_tag    = w_head;
  assign w_commit_fire = commit_valid && commit_ready;

  assign w_cdb_write   = cdb_active && w_cdb_entry.valid && !w_cdb_entry.ready;

  assign count = r_count;

  wrap_pointer #(.DEPTH(ROB_SIZE), .WIDTH(TAG_WIDTH)) u_head_ptr (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (flush),
    .i_inc   (w_commit_fire),
    .o_ptr   (w_head)
  );

  wrap_pointer #(.DEPTH(ROB_SIZE), .WIDTH(TAG_WIDTH)) u_tail_ptr (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (flush),
    .i_inc   (w_alloc_fire),
    .o_ptr   (w_tail)
  );

  // Commit, writeback and allocation never touch the same entry in one cycle:
  // the committing head is already ready (CDB ignored), and the tail slot is
  // invalid when allocated (CDB ignored, and not the head unless empty).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        r_entries[i] <= '0;
      end
    end else if (flush) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        r_entries[i].valid <= 1'b0;
        r_entries[i].ready <= 1'b0;
      end
    end else begin
      if (w_commit_fire) begin
        r_entries[w_head].valid <= 1'b0;
        r_entries[w_head].ready <= 1'b0;
      end
      if (w_cdb_write) begin
        r_entries[cdb_tag].value <= cdb_data;
        r_entries[cdb_tag].ready <= 1'b1;
      end
      if (w_alloc_fire) begin
        r_entries[w_tail].valid <= 1'b1;
        r_entries[w_tail].ready <= 1'b0;
        r_entries[w_tail].rd    <= alloc_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count <= '0;
    end else begin
      case ({w_alloc_fire, w_commit_fire})
        2'b10:   r_count <= r_count + (TAG_WIDTH + 1)'(1);
        2'b01:   r_count <= r_count - (TAG_WIDTH + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_lk1_entry = r_entries[lookup_tag1];
  assign w_lk2_entry = r_entries[lookup_tag2];

  always_comb begin
    lookup_ready1 = w_lk1_entry.valid && w_lk1_entry.ready;
    lookup_value1 = w_lk1_entry.value;
    lookup_ready2 = w_lk2_entry.valid && w_lk2_entry.ready;
    lookup_value2 = w_lk2_entry.value;
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_active && (cdb_tag == lookup_tag1) && w_lk1_entry.valid) begin
      lookup_ready1 = 1'b1;
      lookup_value1 = cdb_data;
    end
    if (cdb_active && (cdb_tag == lookup_tag2) && w_lk2_entry.valid) begin
      lookup_ready2 = 1'b1;
      lookup_value2 = cdb_data;
    end
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a per-cycle vector table for the
// basic allocate/writeback/commit flow plus hand-written corner sequences.
// Committed results are checked against a scoreboard of expected retirements.
module tb_reorder_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_active;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        commit_valid;
  logic        commit_ready;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [2:0]  commit_tag;
  logic [2:0]  lookup_tag1;
  logic [2:0]  lookup_tag2;
  logic        lookup_ready1;
  logic        lookup_ready2;
  logic [31:0] lookup_value1;
  logic [31:0] lookup_value2;
  logic [3:0]  count;

  reorder_buffer #(
    .XLEN(32), .ROB_SIZE(8), .TAG_WIDTH(3), .REG_IDX_WIDTH(5)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_rd(commit_rd), .commit_value(commit_value), .commit_tag(commit_tag),
    .lookup_tag1(lookup_tag1), .lookup_tag2(lookup_tag2),
    .lookup_ready1(lookup_ready1), .lookup_ready2(lookup_ready2),
    .lookup_value1(lookup_value1), .lookup_value2(lookup_value2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [2:0]  tag;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    bit          rst;
    bit          av;
    logic [4:0]  ard;
    logic [31:0] sbval;
    bit          ca;
    logic [2:0]  ct;
    logic [31:0] cd;
    bit          cr;
    bit          e_ar;
    logic [2:0]  e_at;
    logic [3:0]  e_cnt;
    bit          e_cv;
    logic [4:0]  e_crd;
    logic [31:0] e_cval;
    logic [2:0]  e_ctag;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_valid = 0; alloc_rd = '0;
    cdb_active = 0; cdb_tag = '0; cdb_data = '0;
    commit_ready = 0; lookup_tag1 = '0; lookup_tag2 = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Called after settle(): scores any commit about to happen, then advances.
  task automatic tick();
    sb_t e;
    if (!reset && commit_valid && commit_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_commit", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_rd", commit_rd, e.rd);
        chk("sb_value", commit_value, e.val);
        chk("sb_tag", commit_tag, e.tag);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    settle();
    tick();
    reset = 0;
    sb_q.delete();
  endtask

  task automatic alloc_cycle(input logic [4:0] rd, input logic [31:0] val,
                             input logic [2:0] exp_tag);
    idle_inputs();
    alloc_valid = 1; alloc_rd = rd;
    settle();
    chk("alloc_ready", alloc_ready, 1);
    chk("alloc_tag", alloc_tag, exp_tag);
    sb_q.push_back('{rd: rd, val: val, tag: exp_tag});
    tick();
  endtask

  task automatic cdb_cycle(input logic [2:0] tag, input logic [31:0] data);
    idle_inputs();
    cdb_active = 1; cdb_tag = tag; cdb_data = data;
    settle();
    tick();
  endtask

  // Four live entries with tags 0 and 1 ready, used by the flush/reset checks.
  task automatic build_four_two_ready();
    for (int i = 0; i < 4; i++) alloc_cycle(5'(20 + i), 32'(200 + i), 3'(i));
    cdb_cycle(3'd0, 32'd200);
    cdb_cycle(3'd1, 32'd201);
    idle_inputs();
    settle();
    chk("pre_discard_count", count, 4);
    chk("pre_discard_commit_valid", commit_valid, 1);
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
    settle();
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_lookup_ready1", lookup_ready1, 0);
    chk("rst_lookup_ready2", lookup_ready2, 0);
    chk("rst_commit_value", commit_value, 0);
    chk("rst_commit_rd", commit_rd, 0);
    @(negedge clk);

    // rst, av, ard, sbval, ca, ct, cd, cr, e_ar, e_at, e_cnt, e_cv, e_crd, e_cval, e_ctag
    tbl.push_back('{1,0,0,0,  0,0,0,  0, 0,0,0,0,0,0,0});
    tbl.push_back('{0,1,5,24, 0,0,0,  0, 1,0,0,0,0,0,0});
    tbl.push_back('{0,0,0,0,  0,0,0,  0, 1,1,1,0,0,0,0});
    tbl.push_back('{0,0,0,0,  1,0,24, 1, 1,1,1,0,0,0,0});
    tbl.push_back('{0,0,0,0,  0,0,0,  1, 1,1,1,1,5,24,0});
    tbl.push_back('{0,0,0,0,  0,0,0,  0, 1,1,0,0,0,0,1});
    tbl.push_back('{1,0,0,0,  0,0,0,  0, 0,0,0,0,0,0,0});
    tbl.push_back('{0,1,1,3,  0,0,0,  0, 1,0,0,0,0,0,0});
    tbl.push_back('{0,1,2,9,  0,0,0,  0, 1,1,1,0,0,0,0});
    tbl.push_back('{0,1,3,17, 0,0,0,  0, 1,2,2,0,0,0,0});
    tbl.push_back('{0,0,0,0,  1,2,17, 0, 1,3,3,0,0,0,0});
    tbl.push_back('{0,0,0,0,  1,1,9,  0, 1,3,3,0,0,0,0});
    tbl.push_back('{0,0,0,0,  1,0,3,  1, 1,3,3,0,0,0,0});
    tbl.push_back('{0,0,0,0,  0,0,0,  1, 1,3,3,1,1,3,0});
    tbl.push_back('{0,0,0,0,  0,0,0,  1, 1,3,2,1,2,9,1});
    tbl.push_back('{0,0,0,0,  0,0,0,  1, 1,3,1,1,3,17,2});
    tbl.push_back('{0,0,0,0,  0,0,0,  0, 1,3,0,0,0,0,3});

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        idle_inputs();
        alloc_valid  = tbl[i].av;
        alloc_rd     = tbl[i].ard;
        cdb_active   = tbl[i].ca;
        cdb_tag      = tbl[i].ct;
        cdb_data     = tbl[i].cd;
        commit_ready = tbl[i].cr;
        settle();
        chk($sformatf("v%0d_alloc_ready", i), alloc_ready, tbl[i].e_ar);
        chk($sformatf("v%0d_alloc_tag", i), alloc_tag, tbl[i].e_at);
        chk($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
        chk($sformatf("v%0d_commit_valid", i), commit_valid, tbl[i].e_cv);
        chk($sformatf("v%0d_commit_tag", i), commit_tag, tbl[i].e_ctag);
        if (tbl[i].e_cv) begin
          chk($sformatf("v%0d_commit_rd", i), commit_rd, tbl[i].e_crd);
          chk($sformatf("v%0d_commit_value", i), commit_value, tbl[i].e_cval);
        end
        if (tbl[i].av && tbl[i].e_ar)
          sb_q.push_back('{rd: tbl[i].ard, val: tbl[i].sbval, tag: tbl[i].e_at});
        tick();
      end
    end

    // Full ROB: allocation rejected even while the head retires.
    do_reset();
    for (int i = 0; i < 8; i++) alloc_cycle(5'(i), 32'(100 + i), 3'(i));
    idle_inputs();
    settle();
    chk("full_count", count, 8);
    chk("full_alloc_ready", alloc_ready, 0);
    cdb_cycle(3'd0, 32'd100);
    idle_inputs();
    alloc_valid = 1; alloc_rd = 5'd9; commit_ready = 1;
    settle();
    chk("full_commit_alloc_ready", alloc_ready, 0);
    chk("full_commit_valid", commit_valid, 1);
    tick();
    idle_inputs();
    settle();
    chk("after_reject_count", count, 7);
    chk("after_reject_alloc_ready", alloc_ready, 1);
    chk("after_reject_alloc_tag", alloc_tag, 0);
    alloc_cycle(5'd9, 32'd0, 3'd0);
    idle_inputs();
    settle();
    chk("wrap_alloc_count", count, 8);
    chk("wrap_alloc_tag_next", alloc_tag, 1);

    // Lookup and CDB corner cases.
    do_reset();
    for (int i = 0; i < 4; i++) alloc_cycle(5'(10 + i), 32'(50 + i), 3'(i));
    cdb_cycle(3'd5, 32'd77);
    idle_inputs();
    cdb_active = 1; cdb_tag = 3'd3; cdb_data = 32'd42;
    lookup_tag1 = 3'd3; lookup_tag2 = 3'd2;
    settle();
`ifdef ROB_CDB_BYPASS_EN
    chk("bypass_lookup_ready1", lookup_ready1, 1);
    chk("bypass_lookup_value1", lookup_value1, 42);
`else
    chk("nobypass_lookup_ready1", lookup_ready1, 0);
`endif
    chk("lookup_ready2_pending", lookup_ready2, 0);
    tick();
    idle_inputs();
    lookup_tag1 = 3'd3;
    settle();
    chk("stored_lookup_ready1", lookup_ready1, 1);
    chk("stored_lookup_value1", lookup_value1, 42);
    cdb_active = 1; cdb_tag = 3'd3; cdb_data = 32'd99;
    settle();
`ifdef ROB_CDB_BYPASS_EN
    chk("bypass_ready_entry_value", lookup_value1, 99);
`else
    chk("nobypass_ready_entry_value", lookup_value1, 42);
`endif
    tick();
    idle_inputs();
    lookup_tag1 = 3'd3;
    settle();
    chk("ready_entry_cdb_ignored", lookup_value1, 42);
    alloc_cycle(5'd14, 32'd0, 3'd4);
    alloc_cycle(5'd15, 32'd0, 3'd5);
    idle_inputs();
    lookup_tag2 = 3'd5;
    settle();
    chk("invalid_entry_cdb_ignored", lookup_ready2, 0);
    chk("commit_blocked_head_pending", commit_valid, 0);

    // Flush with committable head.
    do_reset();
    build_four_two_ready();
    flush = 1; commit_ready = 1;
    settle();
    chk("flush_commit_valid", commit_valid, 0);
    tick();
    sb_q.delete();
    idle_inputs();
    lookup_tag1 = 3'd1;
    settle();
    chk("flush_count", count, 0);
    chk("flush_alloc_tag", alloc_tag, 0);
    chk("flush_commit_valid_after", commit_valid, 0);
    chk("flush_lookup_ready1", lookup_ready1, 0);
    chk("flush_alloc_ready", alloc_ready, 1);
    @(negedge clk);

    // Same scenario discarded by a mid-operation reset.
    build_four_two_ready();
    reset = 1; commit_ready = 1;
    settle();
    tick();
    reset = 0;
    sb_q.delete();
    idle_inputs();
    lookup_tag1 = 3'd1;
    settle();
    chk("rst2_count", count, 0);
    chk("rst2_alloc_tag", alloc_tag, 0);
    chk("rst2_commit_valid", commit_valid, 0);
    chk("rst2_lookup_ready1", lookup_ready1, 0);
    chk("rst2_commit_value", commit_value, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
